// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master bridge and its wait timer.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  // Counter width able to hold 0..timeout; at least one bit so a disabled timer still elaborates.
  function automatic int timer_w(input int timeout_cyc);
    return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for PREADY and flags the last allowed one.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = timer_w(TIMEOUT_CYC);

  if (TIMEOUT_CYC > 0) begin : g_timer
    logic [CNT_W-1:0] count;

    // Wait counter: cleared before each ACCESS phase, advances on every stalled cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (enable) begin
        count <= count + 1'b1;
      end
    end

    // The stalled cycle seen while at TIMEOUT_CYC-1 is the last one tolerated.
    assign expired = (count == CNT_W'(TIMEOUT_CYC - 1));
  end else begin : g_no_timer
    assign expired = 1'b0;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding command to APB SETUP/ACCESS bridge with registered bus and response.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_e state;
  apb_state_e state_next;
  logic       accept;
  logic       done;
  logic       timeout;
  logic       expired;

  apb_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clear  (state == SETUP),
    .enable ((state == ACCESS) && !PREADY),
    .expired(expired)
  );

  // Next state, command handshake and transfer-end decode.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = SETUP;
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          done       = 1'b1;
          cmd_ready  = 1'b1;
          state_next = cmd_valid ? SETUP : IDLE;
        end else if (expired) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  // State register plus registered bus and response outputs, all derived from the next state.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      PSEL      <= (state_next != IDLE);
      PENABLE   <= (state_next == ACCESS);
      rsp_valid <= done || timeout;
      rsp_err   <= timeout;
      rsp_rdata <= (done && !PWRITE) ? PRDATA : '0;
      if (accept) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized transaction timeline for the APB master bridge, checked cycle by cycle.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int T      = 16;
  localparam int NT     = 150;
  localparam int NC_MAX = 4000;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        pready;
  } stim_t;

  typedef struct packed {
    logic        psel;
    logic        pen;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        rv;
    logic        rerr;
    logic [31:0] rdata;
    logic        ready;
  } exp_t;

  typedef struct {
    apb_cmd_t    cmd;
    int          waits;
    logic [31:0] rdata;
    int          gap;
  } txn_t;

  stim_t stim[NC_MAX];
  exp_t  expv[NC_MAX];
  txn_t  txns[NT];
  int    n_cyc;
  int    cyc;
  logic  active = 1'b0;

  int    n_checks = 0;
  int    n_fail = 0;
  int    run_len = 0;
  int    runs[$];
  logic [32:0] resps[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic set_txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rd, input int gap);
    txns[i].cmd.write = w;
    txns[i].cmd.addr  = a;
    txns[i].cmd.wdata = d;
    txns[i].waits     = waits;
    txns[i].rdata     = rd;
    txns[i].gap       = gap;
  endtask

  task automatic gen_txns();
    set_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1);
    set_txn(1, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 2);
    set_txn(2, 1'b1, 32'h4, 32'h11111111, 0, 32'h0, 1);
    set_txn(3, 1'b1, 32'h8, 32'h22222222, 0, 32'h0, 0);
    set_txn(4, 1'b0, 32'h40, 32'h0, 16, 32'hCAFEF00D, 2);
    set_txn(5, 1'b0, 32'h44, 32'h0, 15, 32'h5A5A5A5A, 1);
    for (int i = 6; i < NT; i++) begin
      int w;
      int g;
      w = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(14, 18));
      g = $urandom_range(0, 3);
      if (txns[i-1].waits >= T && g == 0) g = 1;
      set_txn(i, 1'($urandom), $urandom, $urandom, w, $urandom, g);
    end
  endtask

  // Lays every transaction out on a cycle timeline from the latency rules:
  // accept at A, SETUP in cycle A, k ACCESS cycles, response in cycle A+k+1.
  task automatic build();
    int s;
    int a;
    int k;
    int e;
    int last_e;
    logic chained;
    logic to;
    for (int c = 0; c < NC_MAX; c++) begin
      stim[c].valid  = 1'b0;
      stim[c].write  = 1'($urandom);
      stim[c].addr   = $urandom;
      stim[c].wdata  = $urandom;
      stim[c].prdata = $urandom;
      stim[c].pready = 1'($urandom);
      expv[c] = '0;
      expv[c].ready = 1'b1;
    end
    s = 0;
    a = 0;
    chained = 1'b0;
    last_e = 0;
    for (int i = 0; i < NT; i++) begin
      if (!chained) begin
        a = s + txns[i].gap;
        stim[a-1].valid = 1'b1;
        stim[a-1].write = txns[i].cmd.write;
        stim[a-1].addr  = txns[i].cmd.addr;
        stim[a-1].wdata = txns[i].cmd.wdata;
      end
      for (int c = a; c < NC_MAX; c++) begin
        expv[c].pwrite = txns[i].cmd.write;
        expv[c].paddr  = txns[i].cmd.addr;
        expv[c].pwdata = txns[i].cmd.wdata;
      end
      to = (txns[i].waits >= T);
      k  = to ? T : txns[i].waits + 1;
      expv[a].psel  = 1'b1;
      expv[a].pen   = 1'b0;
      expv[a].ready = 1'b0;
      for (int j = 1; j <= k; j++) begin
        logic pr;
        pr = !to && (j == k);
        expv[a+j].psel  = 1'b1;
        expv[a+j].pen   = 1'b1;
        expv[a+j].ready = pr;
        stim[a+j].pready = pr;
        if (pr) stim[a+j].prdata = txns[i].rdata;
      end
      e = a + k + 1;
      expv[e].rv    = 1'b1;
      expv[e].rerr  = to;
      expv[e].rdata = (!to && !txns[i].cmd.write) ? txns[i].rdata : 32'h0;
      last_e = e;
      if (i + 1 < NT && !to && txns[i+1].gap == 0) begin
        for (int c = a; c <= a + k; c++) begin
          stim[c].valid = 1'b1;
          stim[c].write = txns[i+1].cmd.write;
          stim[c].addr  = txns[i+1].cmd.addr;
          stim[c].wdata = txns[i+1].cmd.wdata;
        end
        a = e;
        chained = 1'b1;
      end else begin
        s = e;
        chained = 1'b0;
      end
    end
    n_cyc = last_e + 3;
  endtask

  task automatic apply(input int c);
    cmd_valid = stim[c].valid;
    cmd_write = stim[c].write;
    cmd_addr  = stim[c].addr;
    cmd_wdata = stim[c].wdata;
    PRDATA    = stim[c].prdata;
    PREADY    = stim[c].pready;
  endtask

  // Per-cycle comparison against the timeline, plus PENABLE-run and response logging.
  always @(negedge PCLK) begin
    if (active) begin
      check($sformatf("c%0d psel", cyc), 64'(PSEL), 64'(expv[cyc].psel));
      check($sformatf("c%0d penable", cyc), 64'(PENABLE), 64'(expv[cyc].pen));
      check($sformatf("c%0d pwrite", cyc), 64'(PWRITE), 64'(expv[cyc].pwrite));
      check($sformatf("c%0d paddr", cyc), 64'(PADDR), 64'(expv[cyc].paddr));
      check($sformatf("c%0d pwdata", cyc), 64'(PWDATA), 64'(expv[cyc].pwdata));
      check($sformatf("c%0d rsp_valid", cyc), 64'(rsp_valid), 64'(expv[cyc].rv));
      check($sformatf("c%0d rsp_err", cyc), 64'(rsp_err), 64'(expv[cyc].rerr));
      check($sformatf("c%0d rsp_rdata", cyc), 64'(rsp_rdata), 64'(expv[cyc].rdata));
      check($sformatf("c%0d cmd_ready", cyc), 64'(cmd_ready), 64'(expv[cyc].ready));
      if (PENABLE) begin
        run_len++;
      end else if (run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
      if (rsp_valid) resps.push_back({rsp_err, rsp_rdata});
    end
  end

  initial begin
    int          exp_runs[6];
    logic [32:0] exp_resps[6];
    exp_runs  = '{1, 4, 1, 1, 16, 16};
    exp_resps = '{{1'b0, 32'h0}, {1'b0, 32'hDEADBEEF}, {1'b0, 32'h0},
                  {1'b0, 32'h0}, {1'b1, 32'h0}, {1'b0, 32'h5A5A5A5A}};

    PRESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PRDATA = '0; PREADY = 1'b0;
    gen_txns();
    build();
    repeat (3) @(posedge PCLK);
    #1;
    check("reset psel", 64'(PSEL), 64'h0);
    check("reset penable", 64'(PENABLE), 64'h0);
    check("reset paddr", 64'(PADDR), 64'h0);
    check("reset pwdata", 64'(PWDATA), 64'h0);
    check("reset rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset cmd_ready", 64'(cmd_ready), 64'h1);

    PRESET = 1'b0;
    cyc = 0;
    apply(0);
    active = 1'b1;
    for (int c = 1; c < n_cyc; c++) begin
      @(posedge PCLK);
      #1;
      cyc = c;
      apply(c);
    end
    @(posedge PCLK);
    #1;
    active = 1'b0;
    cmd_valid = 1'b0;

    check("response count", 64'(resps.size()), 64'(NT));
    for (int i = 0; i < 6; i++) begin
      if (i < runs.size()) check($sformatf("directed penable run %0d", i), 64'(runs[i]), 64'(exp_runs[i]));
      else check($sformatf("directed penable run %0d missing", i), 64'(runs.size()), 64'(i + 1));
      if (i < resps.size()) check($sformatf("directed response %0d", i), 64'(resps[i]), 64'(exp_resps[i]));
      else check($sformatf("directed response %0d missing", i), 64'(resps.size()), 64'(i + 1));
    end

    // Reset during ACCESS, then a clean read to 0x20.
    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; PREADY = 1'b0;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    check("pre-reset in access", 64'(PENABLE), 64'h1);
    @(posedge PCLK); #2;
    PRESET = 1'b1;
    #1;
    check("midreset psel", 64'(PSEL), 64'h0);
    check("midreset penable", 64'(PENABLE), 64'h0);
    check("midreset paddr", 64'(PADDR), 64'h0);
    check("midreset pwrite", 64'(PWRITE), 64'h0);
    check("midreset rsp_valid", 64'(rsp_valid), 64'h0);
    check("midreset rsp_err", 64'(rsp_err), 64'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      check($sformatf("midreset no rsp %0d", i), 64'(rsp_valid), 64'h0);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    check("post-reset no rsp", 64'(rsp_valid), 64'h0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'h0;
    PREADY = 1'b1; PRDATA = 32'h12345678;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    check("read20 setup psel", 64'(PSEL), 64'h1);
    check("read20 setup penable", 64'(PENABLE), 64'h0);
    check("read20 setup paddr", 64'(PADDR), 64'h20);
    check("read20 setup no rsp", 64'(rsp_valid), 64'h0);
    @(posedge PCLK); #1;
    check("read20 access penable", 64'(PENABLE), 64'h1);
    check("read20 access psel", 64'(PSEL), 64'h1);
    @(posedge PCLK); #1;
    check("read20 rsp_valid", 64'(rsp_valid), 64'h1);
    check("read20 rsp_rdata", 64'(rsp_rdata), 64'h12345678);
    check("read20 rsp_err", 64'(rsp_err), 64'h0);
    check("read20 idle psel", 64'(PSEL), 64'h0);
    @(posedge PCLK); #1;
    check("read20 rsp pulse ends", 64'(rsp_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
